// File: rtl/bcp_pkg.sv
// Shared BCP types: scan FSM states, per-clause status, literal polarity encoding.
package bcp_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} scan_state_e;

  typedef enum logic [1:0] {SAT, UNIT, CONFLICT, UNRESOLVED} clause_status_e;

  localparam logic LIT_POS = 1'b1;
  localparam logic LIT_NEG = 1'b0;

endpackage

// File: rtl/bcp_clause_scanner_if.sv
// Loader/sequencer-facing bus of the clause scanner.
// Stats outputs exist only when BCP_SCAN_STATS_EN is defined.
interface bcp_clause_scanner_if #(
  parameter int VAR_NUM    = 8,
  parameter int CLAUSE_NUM = 8,
  parameter int IDX_W      = $clog2(CLAUSE_NUM)
);
  logic               load_en;
  logic [IDX_W-1:0]   load_idx;
  logic [VAR_NUM-1:0] load_mask;
  logic [VAR_NUM-1:0] load_type;
  logic               start;
  logic [VAR_NUM-1:0] assignment;
  logic [VAR_NUM-1:0] free;
  logic               busy;
  logic               done;
  logic               implication_valid;
  logic [VAR_NUM-1:0] implication_var;
  logic               implication_value;
  logic [IDX_W-1:0]   implication_idx;
  logic               conflict;
  logic [IDX_W-1:0]   conflict_idx;
`ifdef BCP_SCAN_STATS_EN
  logic [IDX_W:0]     impl_count;
  logic [IDX_W:0]     sat_count;
`endif

  modport master (
    output load_en, load_idx, load_mask, load_type, start, assignment, free,
    input  busy, done, implication_valid, implication_var, implication_value,
           implication_idx, conflict, conflict_idx
`ifdef BCP_SCAN_STATS_EN
    , input impl_count, sat_count
`endif
  );

  modport slave (
    input  load_en, load_idx, load_mask, load_type, start, assignment, free,
    output busy, done, implication_valid, implication_var, implication_value,
           implication_idx, conflict, conflict_idx
`ifdef BCP_SCAN_STATS_EN
    , output impl_count, sat_count
`endif
  );
endinterface

// File: rtl/bcp_clause_eval.sv
// Combinational single-clause evaluator: classifies a clause against the
// current assignment and reports the implied literal when it is unit.
module bcp_clause_eval
  import bcp_pkg::*;
#(
  parameter int VAR_NUM = 8
) (
  input  logic [VAR_NUM-1:0] mask,
  input  logic [VAR_NUM-1:0] lit_type,
  input  logic [VAR_NUM-1:0] assignment,
  input  logic [VAR_NUM-1:0] free,
  output clause_status_e     status,
  output logic [VAR_NUM-1:0] implied_var,
  output logic               implied_value
);
  logic [VAR_NUM-1:0] sat_bits, open_bits;
  logic               one_open;

  assign sat_bits  = mask & ~free & ~(assignment ^ lit_type);
  assign open_bits = mask & free;
  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign one_open  = (open_bits != '0) && ((open_bits & (open_bits - VAR_NUM'(1))) == '0);

  always_comb begin
    status = UNRESOLVED;
    if (|sat_bits)             status = SAT;
    else if (open_bits == '0)  status = CONFLICT;
    else if (one_open)         status = UNIT;
  end

  assign implied_var   = open_bits;
  assign implied_value = (|(lit_type & open_bits)) ? LIT_POS : LIT_NEG;
endmodule

// File: rtl/bcp_clause_scanner.sv
// Clause bank + one-clause-per-cycle BCP scanner with early exit on conflict.
// Define BCP_SCAN_STATS_EN to add per-pass UNIT/SAT counters.
module bcp_clause_scanner
  import bcp_pkg::*;
#(
  parameter int VAR_NUM    = 8,
  parameter int CLAUSE_NUM = 8,
  parameter int IDX_W      = $clog2(CLAUSE_NUM)
) (
  input  logic                 clock,
  input  logic                 reset,
  bcp_clause_scanner_if.slave  bus
);
  scan_state_e                         state, state_nxt;
  logic [IDX_W-1:0]                    scan_idx, scan_idx_nxt;
  logic [CLAUSE_NUM-1:0]               valid_q;
  logic [CLAUSE_NUM-1:0][VAR_NUM-1:0]  bank_mask, bank_type;

  clause_status_e      cl_status;
  logic [VAR_NUM-1:0]  cl_var;
  logic                cl_val, cl_live, hit_conflict, last_idx, start_pass;

  bcp_clause_eval #(.VAR_NUM(VAR_NUM)) u_eval (
    .mask          (bank_mask[scan_idx]),
    .lit_type      (bank_type[scan_idx]),
    .assignment    (bus.assignment),
    .free          (bus.free),
    .status        (cl_status),
    .implied_var   (cl_var),
    .implied_value (cl_val)
  );

  assign start_pass   = (state == IDLE) && bus.start;
  assign cl_live      = (state == SCAN) && valid_q[scan_idx];
  assign hit_conflict = cl_live && (cl_status == CONFLICT);
  assign last_idx     = (scan_idx == IDX_W'(CLAUSE_NUM - 1));

  always_comb begin
    state_nxt    = state;
    scan_idx_nxt = scan_idx;
    case (state)
      IDLE: if (bus.start) begin
        state_nxt    = SCAN;
        scan_idx_nxt = '0;
      end
      SCAN: if (hit_conflict || last_idx) state_nxt = DONE;
            else                          scan_idx_nxt = scan_idx + IDX_W'(1);
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      scan_idx <= '0;
    end else begin
      state    <= state_nxt;
      scan_idx <= scan_idx_nxt;
    end
  end

  // Loads are only honoured while idle so a pass sees a stable bank.
  always_ff @(posedge clock) begin
    if (reset)                               valid_q <= '0;
    else if (bus.load_en && state == IDLE)   valid_q[bus.load_idx] <= 1'b1;
  end

  always_ff @(posedge clock) begin
    if (bus.load_en && state == IDLE) begin
      bank_mask[bus.load_idx] <= bus.load_mask;
      bank_type[bus.load_idx] <= bus.load_type;
    end
  end

  logic               impl_vld_q, impl_val_q, conf_q;
  logic [VAR_NUM-1:0] impl_var_q;
  logic [IDX_W-1:0]   impl_idx_q, conf_idx_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      impl_vld_q <= 1'b0;
      impl_val_q <= 1'b0;
      impl_var_q <= '0;
      impl_idx_q <= '0;
      conf_q     <= 1'b0;
      conf_idx_q <= '0;
    end else begin
      impl_vld_q <= 1'b0;
      if (cl_live && cl_status == UNIT) begin
        impl_vld_q <= 1'b1;
        impl_var_q <= cl_var;
        impl_val_q <= cl_val;
        impl_idx_q <= scan_idx;
      end
      if (start_pass) conf_q <= 1'b0;
      if (hit_conflict) begin
        conf_q     <= 1'b1;
        conf_idx_q <= scan_idx;
      end
    end
  end

  assign bus.busy              = (state == SCAN);
  assign bus.done              = (state == DONE);
  assign bus.implication_valid = impl_vld_q;
  assign bus.implication_var   = impl_var_q;
  assign bus.implication_value = impl_val_q;
  assign bus.implication_idx   = impl_idx_q;
  assign bus.conflict          = conf_q;
  assign bus.conflict_idx      = conf_idx_q;

`ifdef BCP_SCAN_STATS_EN
  logic [IDX_W:0] impl_cnt_q, sat_cnt_q;

  always_ff @(posedge clock) begin
    if (reset || start_pass) begin
      impl_cnt_q <= '0;
      sat_cnt_q  <= '0;
    end else if (cl_live) begin
      if (cl_status == UNIT) impl_cnt_q <= impl_cnt_q + (IDX_W+1)'(1);
      if (cl_status == SAT)  sat_cnt_q  <= sat_cnt_q + (IDX_W+1)'(1);
    end
  end

  assign bus.impl_count = impl_cnt_q;
  assign bus.sat_count  = sat_cnt_q;
`endif
endmodule
